// File: rtl/load_queue_param.sv
// Load queue: circular buffer of in-flight loads with a single-issue cache FSM.
// Optional macro LQ_FWD_EN enables capturing store-queue forwarded data.
module load_queue_param #(
  parameter int DEPTH   = 16,
  parameter int ALLOC_W = 4,
  parameter int TAG_W   = 6,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  localparam int IW     = $clog2(DEPTH),
  localparam int PW     = IW + 1,
  localparam int CW     = $clog2(ALLOC_W) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ALLOC_W-1:0]       vld_al,
  input  logic [ALLOC_W*TAG_W-1:0] indx_al,
  input  logic [ALLOC_W*TAG_W-1:0] phy_al,
  input  logic                     addr_vld,
  input  logic [TAG_W-1:0]         addr_tag,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     ld_req,
  output logic [ADDR_W-1:0]        ld_addr,
  input  logic                     ld_grnt,
  input  logic                     done,
  input  logic [DATA_W-1:0]        data_ca,
  input  logic                     fwd,
  input  logic                     fwd_rdy,
  input  logic [DATA_W-1:0]        data_sq,
  output logic                     wb_vld,
  output logic [TAG_W-1:0]         wb_tag,
  output logic [TAG_W-1:0]         wb_phy,
  output logic [DATA_W-1:0]        wb_data,
  input  logic [CW-1:0]            cmmt_cnt,
  input  logic                     flsh,
  input  logic [PW-1:0]            mis_ptr,
  output logic                     stll,
  output logic [PW-1:0]            count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_head, r_tail;
  logic [DEPTH-1:0]    r_vld, r_ardy, r_done;
  logic [TAG_W-1:0]    r_tag  [DEPTH];
  logic [TAG_W-1:0]    r_phy  [DEPTH];
  logic [ADDR_W-1:0]   r_addr [DEPTH];
  logic [IW-1:0]       r_sel;
  logic [ADDR_W-1:0]   r_ld_addr;
  logic [TAG_W-1:0]    r_wb_tag, r_wb_phy;
  logic [DATA_W-1:0]   r_wb_data;

  logic [PW-1:0]       w_count, w_free, w_cmmt_req, w_cmmt, w_nalloc, w_fl_span;
  logic                w_full, w_empty, w_stll, w_alloc_en;
  logic [IW-1:0]       w_slot [ALLOC_W];
  logic [IW-1:0]       w_scan, w_pick;
  logic                w_found;
  logic [DEPTH-1:0]    w_fl, w_cm;
  logic                w_cap;
  logic [DATA_W-1:0]   w_cap_data;

  assign w_count   = r_tail - r_head;
  assign w_free    = PW'(DEPTH) - w_count;
  assign w_full    = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
  assign w_empty   = (r_head == r_tail);
  // Stall once a whole group would exhaust the free slots; the stall is all-or-nothing.
  assign w_stll    = w_full || (w_free <= PW'(ALLOC_W));
  assign w_alloc_en = !w_stll && !flsh;
  assign w_cmmt_req = PW'(cmmt_cnt);
  assign w_cmmt    = w_empty ? '0 : ((w_cmmt_req > w_count) ? w_count : w_cmmt_req);
  assign w_fl_span = r_tail - mis_ptr;

  always_comb begin
    w_nalloc = '0;
    for (int l = 0; l < ALLOC_W; l++) begin
      w_slot[l] = r_tail[IW-1:0] + w_nalloc[IW-1:0];
      w_nalloc  = w_nalloc + PW'(vld_al[l]);
    end
  end

  // Oldest eligible entry: scan forward from head.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_head[IW-1:0];
    w_scan  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan = r_head[IW-1:0] + IW'(k);
      if (!w_found && r_vld[w_scan] && r_ardy[w_scan] && !r_done[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
    end
  end

  always_comb begin
    w_fl = '0;
    w_cm = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_fl[j] = ({1'b0, IW'(j) - mis_ptr[IW-1:0]} < w_fl_span);
      w_cm[j] = ({1'b0, IW'(j) - r_head[IW-1:0]} < w_cmmt);
    end
  end

`ifdef LQ_FWD_EN
  logic w_fwd_hit;
  assign w_fwd_hit  = fwd && fwd_rdy;
  assign w_cap      = done || w_fwd_hit;
  assign w_cap_data = w_fwd_hit ? data_sq : data_ca;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd, fwd_rdy, data_sq};
  assign w_cap      = done;
  assign w_cap_data = data_ca;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found && !(flsh && w_fl[w_pick])) w_state_nxt = S_REQ;
      S_REQ:  if (ld_grnt) w_state_nxt = S_WAIT;
      S_WAIT: if (w_cap) w_state_nxt = S_WB;
      S_WB:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flsh && r_state != S_IDLE && w_fl[r_sel]) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_vld     <= '0;
      r_ardy    <= '0;
      r_done    <= '0;
      r_ld_addr <= '0;
      r_wb_tag  <= '0;
      r_wb_phy  <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= r_head + w_cmmt;
      if (flsh)            r_tail <= mis_ptr;
      else if (w_alloc_en) r_tail <= r_tail + w_nalloc;
      for (int j = 0; j < DEPTH; j++) begin
        if (addr_vld && r_vld[j] && r_tag[j] == addr_tag) r_ardy[j] <= 1'b1;
        if (r_state == S_WB && r_sel == IW'(j)) r_done[j] <= 1'b1;
      end
      for (int l = 0; l < ALLOC_W; l++) begin
        if (w_alloc_en && vld_al[l]) begin
          r_vld[w_slot[l]]  <= 1'b1;
          r_ardy[w_slot[l]] <= 1'b0;
          r_done[w_slot[l]] <= 1'b0;
        end
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (w_cm[j] || (flsh && w_fl[j])) r_vld[j] <= 1'b0;
      end
      if (r_state == S_IDLE && w_found) begin
        r_ld_addr <= r_addr[w_pick];
        r_wb_tag  <= r_tag[w_pick];
        r_wb_phy  <= r_phy[w_pick];
      end
      if (r_state == S_WAIT && w_cap) r_wb_data <= w_cap_data;
    end
  end

  // Entry payload needs no reset: every use is qualified by r_vld or the FSM state.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (addr_vld && r_vld[j] && r_tag[j] == addr_tag) r_addr[j] <= addr;
    end
    for (int l = 0; l < ALLOC_W; l++) begin
      if (w_alloc_en && vld_al[l]) begin
        r_tag[w_slot[l]] <= indx_al[l*TAG_W +: TAG_W];
        r_phy[w_slot[l]] <= phy_al[l*TAG_W +: TAG_W];
      end
    end
    if (r_state == S_IDLE && w_found) r_sel <= w_pick;
  end

  assign ld_req  = (r_state == S_REQ);
  assign ld_addr = r_ld_addr;
  assign wb_vld  = (r_state == S_WB);
  assign wb_tag  = r_wb_tag;
  assign wb_phy  = r_wb_phy;
  assign wb_data = r_wb_data;
  assign stll    = w_stll;
  assign count   = w_count;

endmodule

// File: tb/tb_load_queue_param.sv
// Bench for load_queue_param: queue-based reference model plus directed vectors.
module tb_load_queue_param;
  localparam int DEPTH = 16, ALLOC_W = 4, TAG_W = 6, ADDR_W = 16, DATA_W = 16;
  localparam int PW = 5, CW = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic [ALLOC_W-1:0] vld_al = '0;
  logic [ALLOC_W*TAG_W-1:0] indx_al = '0, phy_al = '0;
  logic addr_vld = 1'b0;
  logic [TAG_W-1:0] addr_tag = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic ld_req, ld_grnt = 1'b0, done = 1'b0;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] data_ca = '0, data_sq = '0;
  logic fwd = 1'b0, fwd_rdy = 1'b0;
  logic wb_vld;
  logic [TAG_W-1:0] wb_tag, wb_phy;
  logic [DATA_W-1:0] wb_data;
  logic [CW-1:0] cmmt_cnt = '0;
  logic flsh = 1'b0;
  logic [PW-1:0] mis_ptr = '0;
  logic stll;
  logic [PW-1:0] count;

  always #5 clk = ~clk;

  load_queue_param #(.DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .TAG_W(TAG_W),
                     .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .vld_al(vld_al), .indx_al(indx_al), .phy_al(phy_al),
    .addr_vld(addr_vld), .addr_tag(addr_tag), .addr(addr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grnt(ld_grnt), .done(done), .data_ca(data_ca),
    .fwd(fwd), .fwd_rdy(fwd_rdy), .data_sq(data_sq),
    .wb_vld(wb_vld), .wb_tag(wb_tag), .wb_phy(wb_phy), .wb_data(wb_data),
    .cmmt_cnt(cmmt_cnt), .flsh(flsh), .mis_ptr(mis_ptr), .stll(stll), .count(count));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: list of live entries from head to tail.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  phy;
    logic [ADDR_W-1:0] addr;
    logic              ardy;
    logic              dn;
  } ent_t;

  ent_t mq[$];
  int m_head = 0;
  int snap_ptr = -1, pend_ptr = -1;
  logic [ADDR_W-1:0] snap_addr;
  logic [TAG_W-1:0] snap_tag, snap_phy, pend_tag, pend_phy;
  bit wb_seen = 0, prev_ldreq = 0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_head = 0; pend_ptr = -1; snap_ptr = -1; wb_seen = 0;
    end else begin
      int sz, c, keep, k;
      bit stl;
      ent_t e;
      if (wb_seen && pend_ptr >= 0) begin
        k = (pend_ptr - m_head + 2*DEPTH) % (2*DEPTH);
        if (k < mq.size()) mq[k].dn = 1'b1;
        pend_ptr = -1;
      end
      wb_seen = 0;
      snap_ptr = -1;
      for (int i = 0; i < mq.size(); i++)
        if (snap_ptr < 0 && mq[i].ardy && !mq[i].dn) begin
          snap_ptr = (m_head + i) % (2*DEPTH);
          snap_addr = mq[i].addr; snap_tag = mq[i].tag; snap_phy = mq[i].phy;
        end
      sz = mq.size();
      c = (int'(cmmt_cnt) > sz) ? sz : int'(cmmt_cnt);
      stl = (DEPTH - sz) <= ALLOC_W;
      if (addr_vld)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].tag == addr_tag) begin mq[i].addr = addr; mq[i].ardy = 1'b1; end
      if (flsh) begin
        keep = (int'(mis_ptr) - m_head + 2*DEPTH) % (2*DEPTH);
        while (mq.size() > keep) void'(mq.pop_back());
        if (pend_ptr >= 0 && ((pend_ptr - m_head + 2*DEPTH) % (2*DEPTH)) >= keep) pend_ptr = -1;
      end else if (!stl) begin
        for (int l = 0; l < ALLOC_W; l++)
          if (vld_al[l]) begin
            e.tag = indx_al[l*TAG_W +: TAG_W]; e.phy = phy_al[l*TAG_W +: TAG_W];
            e.addr = '0; e.ardy = 1'b0; e.dn = 1'b0;
            mq.push_back(e);
          end
      end
      for (int i = 0; i < c; i++) void'(mq.pop_front());
      m_head = (m_head + c) % (2*DEPTH);
    end
  end

  always @(negedge clk) begin
    if (!rst) prev_ldreq = 0;
    else begin
      chk("count_model", 32'(count), 32'(mq.size()));
      chk("stll_model", 32'(stll), 32'((DEPTH - mq.size()) <= ALLOC_W));
      if (ld_req && !prev_ldreq) begin
        if (snap_ptr < 0) chk("issue_unexpected", 32'(ld_req), 32'd0);
        else begin
          chk("ld_addr_model", 32'(ld_addr), 32'(snap_addr));
          pend_ptr = snap_ptr; pend_tag = snap_tag; pend_phy = snap_phy;
        end
      end
      if (wb_vld) begin
        if (pend_ptr < 0) chk("wb_unexpected", 32'(wb_vld), 32'd0);
        else begin
          chk("wb_tag_model", 32'(wb_tag), 32'(pend_tag));
          chk("wb_phy_model", 32'(wb_phy), 32'(pend_phy));
          wb_seen = 1;
        end
      end
      prev_ldreq = ld_req;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_alloc(input logic [ALLOC_W-1:0] v, input int base);
    vld_al = v;
    for (int l = 0; l < ALLOC_W; l++) begin
      indx_al[l*TAG_W +: TAG_W] = TAG_W'(base + l);
      phy_al[l*TAG_W +: TAG_W]  = TAG_W'(base + l + 32);
    end
  endtask

  task automatic issue_and_grant(input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] a);
    addr_vld = 1'b1; addr_tag = t; addr = a;
    step();
    addr_vld = 1'b0;
    chk("ld_req_idle", 32'(ld_req), 32'd0);
    step();
    chk("ld_req_on", 32'(ld_req), 32'd1);
    chk("ld_addr", 32'(ld_addr), 32'(a));
    ld_grnt = 1'b1;
    step();
    ld_grnt = 1'b0;
    chk("ld_req_after_grant", 32'(ld_req), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_fwd;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stll", 32'(stll), 32'd0);
    chk("rst_ld_req", 32'(ld_req), 32'd0);
    chk("rst_wb_vld", 32'(wb_vld), 32'd0);
    chk("rst_ld_addr", 32'(ld_addr), 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    rst = 1'b1;
    step();

    // Four full groups: the fourth is rejected.
    for (int g = 0; g < 4; g++) begin
      set_alloc(4'b1111, 8 + 4*g);
      step();
      chk("alloc_count", 32'(count), (g < 3) ? 32'(4*(g+1)) : 32'd12);
      chk("alloc_stll", 32'(stll), (g >= 2) ? 32'd1 : 32'd0);
    end
    vld_al = '0;

    cmmt_cnt = 3'd4; step(); chk("cmmt_to8", 32'(count), 32'd8);
    cmmt_cnt = 3'd2; step(); chk("cmmt_to6", 32'(count), 32'd6);
    cmmt_cnt = 3'd4; step(); chk("cmmt_to2", 32'(count), 32'd2);
    cmmt_cnt = 3'd4; step(); chk("cmmt_clamp", 32'(count), 32'd0);
    cmmt_cnt = '0;

    // Head = tail = 12; walk the tail across the wrap point.
    set_alloc(4'b0011, 40); step(); chk("wrap_cnt2", 32'(count), 32'd2);
    set_alloc(4'b1111, 42); step(); chk("wrap_cnt6", 32'(count), 32'd6);
    chk("wrap_tail", 32'(dut.r_tail), 32'd18);
    set_alloc(4'b1111, 46); step(); chk("wrap_cnt10", 32'(count), 32'd10);
    set_alloc(4'b1111, 50); step(); chk("wrap_cnt14", 32'(count), 32'd14);
    chk("wrap_stll", 32'(stll), 32'd1);
    step(); chk("wrap_reject", 32'(count), 32'd14);
    vld_al = '0;
    cmmt_cnt = 3'd4;
    for (int i = 0; i < 4; i++) step();
    cmmt_cnt = '0;
    chk("wrap_drain", 32'(count), 32'd0);

    // Two loads, tags 1 and 3; tag 3 gets its address first.
    vld_al = 4'b0011;
    indx_al = '0; phy_al = '0;
    indx_al[0 +: TAG_W] = 6'd1;  indx_al[TAG_W +: TAG_W] = 6'd3;
    phy_al[0 +: TAG_W]  = 6'd21; phy_al[TAG_W +: TAG_W]  = 6'd23;
    step();
    vld_al = '0;
    chk("ld_count2", 32'(count), 32'd2);
    addr_vld = 1'b1; addr_tag = 6'd3; addr = 16'habcd;
    step();
    addr_vld = 1'b0;
    step();
    chk("req_on", 32'(ld_req), 32'd1);
    chk("req_addr", 32'(ld_addr), 32'habcd);
    step();
    chk("req_hold", 32'(ld_req), 32'd1);
    chk("req_addr_hold", 32'(ld_addr), 32'habcd);
    ld_grnt = 1'b1; step(); ld_grnt = 1'b0;
    chk("wait_no_req", 32'(ld_req), 32'd0);
    chk("wait_no_wb", 32'(wb_vld), 32'd0);
    done = 1'b1; data_ca = 16'hffff; step(); done = 1'b0;
    chk("wb_vld", 32'(wb_vld), 32'd1);
    chk("wb_tag", 32'(wb_tag), 32'd3);
    chk("wb_phy", 32'(wb_phy), 32'd23);
    chk("wb_data", 32'(wb_data), 32'hffff);
    step();
    chk("wb_one_cycle", 32'(wb_vld), 32'd0);

    // Forward and cache data arrive together.
    issue_and_grant(6'd1, 16'h1234);
    fwd = 1'b1; fwd_rdy = 1'b1; data_sq = 16'h1111; done = 1'b1; data_ca = 16'h2222;
    step();
    fwd = 1'b0; fwd_rdy = 1'b0; done = 1'b0;
`ifdef LQ_FWD_EN
    exp_fwd = 16'h1111;
`else
    exp_fwd = 16'h2222;
`endif
    chk("fwd_wb_vld", 32'(wb_vld), 32'd1);
    chk("fwd_wb_tag", 32'(wb_tag), 32'd1);
    chk("fwd_wb_data", 32'(wb_data), 32'(exp_fwd));
    step();
    cmmt_cnt = 3'd2; step(); cmmt_cnt = '0;
    chk("fwd_drain", 32'(count), 32'd0);

    // Flush while waiting on entry 8.
    rst = 1'b0; step(); rst = 1'b1; step();
    chk("rst2_count", 32'(count), 32'd0);
    set_alloc(4'b1111, 0); step();
    set_alloc(4'b1111, 4); step();
    set_alloc(4'b0011, 8); step();
    vld_al = '0;
    chk("fl_count10", 32'(count), 32'd10);
    issue_and_grant(6'd8, 16'h0808);
    flsh = 1'b1; mis_ptr = 5'd7; set_alloc(4'b1111, 60);
    step();
    flsh = 1'b0; vld_al = '0;
    chk("fl_count7", 32'(count), 32'd7);
    chk("fl_no_req", 32'(ld_req), 32'd0);
    chk("fl_no_wb", 32'(wb_vld), 32'd0);
    done = 1'b1; data_ca = 16'hdead; step(); done = 1'b0;
    chk("fl_late_done", 32'(wb_vld), 32'd0);
    step();
    chk("fl_late_done2", 32'(wb_vld), 32'd0);
    addr_vld = 1'b1; addr_tag = 6'd8; addr = 16'h0999; step(); addr_vld = 1'b0;
    step(); step();
    chk("fl_tag_dropped", 32'(ld_req), 32'd0);

    // Reset in the middle of a load.
    issue_and_grant(6'd2, 16'h0202);
    rst = 1'b0; #1;
    chk("mid_rst_req", 32'(ld_req), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ld_addr", 32'(ld_addr), 32'd0);
    chk("mid_rst_wb_tag", 32'(wb_tag), 32'd0);
    step();
    rst = 1'b1;
    done = 1'b1; step(); done = 1'b0;
    chk("mid_rst_late_done", 32'(wb_vld), 32'd0);
    step();
    chk("mid_rst_idle_wb", 32'(wb_vld), 32'd0);
    chk("mid_rst_idle_req", 32'(ld_req), 32'd0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
